// File: rtl/tim_apb_master.sv
// Single-outstanding APB master bridge for the timer slave port.
// Turns a valid/ready request/response pair into APB SETUP/ACCESS sequences with a wait-state timeout.
module tim_apb_master #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  tim_psel,
    output logic                  tim_penable,
    output logic                  tim_pwrite,
    output logic [ADDR_W-1:0]     tim_paddr,
    output logic [DATA_W-1:0]     tim_pwdata,
    output logic [DATA_W/8-1:0]   tim_pstrb,
    input  logic [DATA_W-1:0]     tim_prdata,
    input  logic                  tim_pready,
    input  logic                  tim_pslverr
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_req_ready;
    logic                  r_busy;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;
    logic [DATA_W/8-1:0]   r_pstrb;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_timeout_hit;

    // Saturating wait-state count; the limit is tested against the post-increment value
    // so the abort lands on the edge that ends the TIMEOUT_CYC-th stalled ACCESS cycle.
    assign w_cnt_next    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout_hit = (TIMEOUT_CYC > 0) && (w_cnt_next == CNT_LIM);

    // NOTE: all state here is updated with non-blocking assignments so every branch reads
    // the pre-edge values; blocking assignments would leak next-state values into later lines.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pwrite    <= req_write;
                        r_paddr     <= req_addr;
                        r_pwdata    <= req_wdata;
                        r_pstrb     <= req_write ? req_strb : '0;
                        if (req_addr[1:0] != 2'b00) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_psel  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (tim_pready) begin
                        r_state     <= S_RESP;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= tim_pslverr;
                        r_rsp_rdata <= (!r_pwrite && !tim_pslverr) ? tim_prdata : '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_timeout_hit) begin
                            r_state       <= S_RESP;
                            r_psel        <= 1'b0;
                            r_penable     <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b1;
                            r_rsp_rdata   <= '0;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state       <= S_IDLE;
                        r_req_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_rsp_valid   <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign busy        = r_busy;
    assign tim_psel    = r_psel;
    assign tim_penable = r_penable;
    assign tim_pwrite  = r_pwrite;
    assign tim_paddr   = r_paddr;
    assign tim_pwdata  = r_pwdata;
    assign tim_pstrb   = r_pstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_tim_apb_master.sv
// Directed bench for tim_apb_master: a response scoreboard fed by the stimulus and
// drained by a monitor, plus inline APB timing checks against a scripted slave.
module tb_tim_apb_master;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              tmo;
    } rsp_t;

    logic                sys_clk = 1'b0;
    logic                sys_rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_strb;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                rsp_timeout;
    logic                busy;
    logic                tim_psel;
    logic                tim_penable;
    logic                tim_pwrite;
    logic [ADDR_W-1:0]   tim_paddr;
    logic [DATA_W-1:0]   tim_pwdata;
    logic [DATA_W/8-1:0] tim_pstrb;
    logic [DATA_W-1:0]   tim_prdata;
    logic                tim_pready;
    logic                tim_pslverr;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    // Slave script: pready rises on ACCESS cycle index slv_wait (0 = first ACCESS cycle).
    int                slv_wait   = 0;
    logic              slv_err    = 1'b0;
    logic [DATA_W-1:0] slv_rdata  = '0;
    int                slv_k      = 0;

    tim_apb_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .tim_psel   (tim_psel),
        .tim_penable(tim_penable),
        .tim_pwrite (tim_pwrite),
        .tim_paddr  (tim_paddr),
        .tim_pwdata (tim_pwdata),
        .tim_pstrb  (tim_pstrb),
        .tim_prdata (tim_prdata),
        .tim_pready (tim_pready),
        .tim_pslverr(tim_pslverr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave responds mid-cycle, well before the edge that samples pready.
    initial begin
        tim_pready  = 1'b0;
        tim_pslverr = 1'b0;
        tim_prdata  = '0;
        forever begin
            @(negedge sys_clk);
            if (tim_psel && tim_penable) begin
                tim_pready  = (slv_k >= slv_wait);
                tim_pslverr = (slv_k >= slv_wait) ? slv_err : 1'b0;
                tim_prdata  = slv_rdata;
                slv_k++;
            end else begin
                tim_pready  = 1'b0;
                tim_pslverr = 1'b0;
                slv_k       = 0;
            end
        end
    end

    // Response monitor: pops one expected entry per completed response handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                end
            end
        end
    end

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic er, input logic tm);
        rsp_t e;
        e.rdata = d;
        e.err   = er;
        e.tmo   = tm;
        exp_q.push_back(e);
    endtask

    // Returns 1 ns after the edge that ends the accept cycle T, i.e. early in cycle T+1.
    task automatic send(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s);
        bit acc;
        acc       = 1'b0;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge sys_clk);
            acc = req_ready;
            @(posedge sys_clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge sys_clk);
            idle = !busy;
        end
        if (!idle) check("idle_timeout", 0, 1);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int n;
        sys_rst   = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_outputs", {rsp_valid, rsp_err, rsp_timeout, busy, tim_psel, tim_penable,
                              tim_pwrite}, 7'b0);
        check("rst_paddr_pstrb", {tim_paddr, tim_pstrb}, '0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        // Zero-wait write: SETUP at T+1, ACCESS at T+2, response at T+3.
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hCAFE_F00D;
        push_exp(32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h000, 32'h0000_0003, 4'hF);
        @(negedge sys_clk);
        check("wr_setup", {tim_psel, tim_penable, tim_pwrite}, 3'b101);
        check("wr_setup_bus", {tim_paddr, tim_pwdata, tim_pstrb}, {12'h000, 32'h3, 4'hF});
        @(negedge sys_clk);
        check("wr_access", {tim_psel, tim_penable}, 2'b11);
        @(negedge sys_clk);
        check("wr_resp", {rsp_valid, tim_psel, tim_penable}, 3'b100);
        wait_idle();

        // Read with three wait states: four stable ACCESS cycles, strobes zero.
        slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
        push_exp(32'hDEAD_BEEF, 1'b0, 1'b0);
        send(1'b0, 12'h004, 32'h1111_1111, 4'hF);
        @(negedge sys_clk);
        check("rd_setup", {tim_psel, tim_penable, tim_pstrb}, {2'b10, 4'h0});
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            check("rd_access_hold", {tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pstrb},
                  {3'b110, 12'h004, 4'h0});
        end
        @(negedge sys_clk);
        check("rd_resp_valid", {rsp_valid, tim_psel}, 2'b10);
        wait_idle();

        // Slave error: data forced to zero even though the slave drives prdata.
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h1234_5678;
        push_exp(32'h0, 1'b1, 1'b0);
        send(1'b0, 12'h008, 32'h0, 4'h0);
        wait_idle();
        slv_err = 1'b0;

        // Stuck pready: abort after exactly 16 stalled ACCESS cycles.
        slv_wait = 1000;
        push_exp(32'h0, 1'b1, 1'b1);
        send(1'b0, 12'h00C, 32'h0, 4'h0);
        @(negedge sys_clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (!tim_psel) break;
            if (tim_penable) n++;
        end
        check("tmo_access_cycles", n, 16);
        check("tmo_rsp_valid", rsp_valid, 1);
        wait_idle();
        slv_wait = 0;
        push_exp(32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h010, 32'h0000_0055, 4'h3);
        @(negedge sys_clk);
        check("post_tmo_setup", {tim_psel, tim_penable, tim_pstrb}, {2'b10, 4'h3});
        wait_idle();

        // Misaligned request: no APB activity, error response one cycle after accept.
        push_exp(32'h0, 1'b1, 1'b0);
        send(1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF);
        @(negedge sys_clk);
        check("mis_resp", {rsp_valid, tim_psel, tim_penable}, 3'b100);
        wait_idle();

        // Back-pressure in RESP with a second request already waiting.
        rsp_ready = 1'b0; slv_rdata = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        send(1'b0, 12'h004, 32'h0, 4'h0);
        push_exp(32'h0, 1'b0, 1'b0);
        req_write = 1'b1; req_addr = 12'h014; req_wdata = 32'hA5A5_A5A5; req_strb = 4'hF;
        req_valid = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            check("bp_hold", {rsp_valid, req_ready, tim_psel, rsp_err, rsp_rdata},
                  {4'b1000, 32'h1234_5678});
        end
        @(posedge sys_clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge sys_clk);
        check("bp_release_valid", rsp_valid, 1);
        @(negedge sys_clk);
        check("bp_idle", {req_ready, rsp_valid, tim_psel}, 3'b100);
        @(negedge sys_clk);
        check("bp_next_setup", {tim_psel, tim_penable, tim_paddr}, {2'b10, 12'h014});
        @(posedge sys_clk);
        #1;
        req_valid = 1'b0;
        wait_idle();

        // Reset during ACCESS kills the transfer with no response.
        slv_wait = 1000;
        send(1'b0, 12'h018, 32'h0, 4'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("kill_in_access", {tim_psel, tim_penable}, 2'b11);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("kill_outputs", {tim_psel, tim_penable, rsp_valid, req_ready}, 4'b0001);
        sys_rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("kill_quiet", {busy, rsp_valid}, 2'b00);
        @(posedge sys_clk);
        #1;
        slv_wait = 0;
        push_exp(32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h01C, 32'h0000_00AA, 4'h1);
        wait_idle();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge sys_clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
